// File: rtl/dot_arb_pkg.sv
// dot_arb_pkg: shared state encoding and operand geometry for the dot arbiter slice
package dot_arb_pkg;
  localparam int VEC_W = 32;
  localparam int Q_BITS = 16;
  localparam int VEC_N = 3;
  typedef enum logic {S_IDLE, S_STAGED} state_t;
endpackage

// File: rtl/dot_tag_fifo.sv
// dot_tag_fifo: in-order tag FIFO recording which requester owns each in-flight dot op
module dot_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // a pop in the same cycle frees the slot a full FIFO needs for the push
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? bump(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/dot_arbiter.sv
// dot_arbiter: round-robin sharing of one dot unit among NUM_REQ requesters,
// with an in-order tag FIFO steering each result back to its requester.
module dot_arbiter
  import dot_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 8,
  localparam int TAG_W = $clog2(NUM_REQ),
  localparam int CNT_W = $clog2(MAX_OUT + 1)
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0][VEC_N-1:0][VEC_W-1:0]      req_x,
  input  logic [NUM_REQ-1:0][VEC_N-1:0][VEC_W-1:0]      req_y,
  input  logic [NUM_REQ-1:0]                            req_empty,
  output logic [NUM_REQ-1:0]                            req_rd_en,
  output logic [VEC_N-1:0][VEC_W-1:0]                   dot_x,
  output logic [VEC_N-1:0][VEC_W-1:0]                   dot_y,
  output logic                                          dot_empty,
  input  logic                                          dot_rd_en,
  input  logic signed [VEC_W-1:0]                       dot_out,
  input  logic                                          dot_out_empty,
  output logic                                          dot_out_rd_en,
  output logic signed [VEC_W-1:0]                       res_out,
  output logic [NUM_REQ-1:0]                            res_empty,
  input  logic [NUM_REQ-1:0]                            res_rd_en,
  output logic [CNT_W-1:0]                              outstanding
);
  state_t state_q, state_d;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d, stag_q, stag_d, gnt_idx, head_tag;
  logic [VEC_N-1:0][VEC_W-1:0] dot_x_q, dot_x_d, dot_y_q, dot_y_d;
  logic [CNT_W:0] in_flight;
  logic gnt_any, consume, can_load, grant, tag_empty, tag_full, res_valid;

  function automatic logic [TAG_W-1:0] rr_idx(input logic [TAG_W-1:0] base, input int off);
    return TAG_W'((int'(base) + off) % NUM_REQ);
  endfunction

  // scan downward so the candidate nearest rr_ptr is the last one written
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (!req_empty[rr_idx(rr_ptr_q, i)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx(rr_ptr_q, i);
      end
    end
  end

  // a staged op consumed this cycle counts toward the limit before the reload
  always_comb begin
    consume   = (state_q == S_STAGED) && dot_rd_en;
    can_load  = (state_q == S_IDLE) || consume;
    in_flight = {1'b0, outstanding} + (CNT_W + 1)'(consume);
    grant     = !reset && can_load && gnt_any && (in_flight < (CNT_W + 1)'(MAX_OUT));
    req_rd_en = grant ? NUM_REQ'(1) << gnt_idx : '0;
    state_d   = grant ? S_STAGED : consume ? S_IDLE : state_q;
    rr_ptr_d  = grant ? rr_idx(gnt_idx, 1) : rr_ptr_q;
    stag_d    = grant ? gnt_idx : stag_q;
    dot_x_d   = grant ? req_x[gnt_idx] : dot_x_q;
    dot_y_d   = grant ? req_y[gnt_idx] : dot_y_q;
  end

  always_comb begin
    res_valid     = !tag_empty && !dot_out_empty;
    res_empty     = ~(res_valid ? NUM_REQ'(1) << head_tag : NUM_REQ'(0));
    dot_out_rd_en = res_valid && res_rd_en[head_tag];
    res_out       = dot_out;
  end

  assign dot_empty = (state_q != S_STAGED);
  assign dot_x     = dot_x_q;
  assign dot_y     = dot_y_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      stag_q   <= '0;
      dot_x_q  <= '0;
      dot_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      stag_q   <= stag_d;
      dot_x_q  <= dot_x_d;
      dot_y_q  <= dot_y_d;
    end
  end

  dot_tag_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUT)) u_tags (
    .clock (clock),
    .reset (reset),
    .push  (consume),
    .din   (stag_q),
    .pop   (dot_out_rd_en),
    .dout  (head_tag),
    .empty (tag_empty),
    .full  (tag_full),
    .count (outstanding)
  );

  a_grant_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(req_rd_en));
  a_no_empty_pop: assert property (@(posedge clock) disable iff (reset) (req_rd_en & req_empty) == '0);
  a_out_limit:    assert property (@(posedge clock) disable iff (reset) outstanding <= CNT_W'(MAX_OUT));
  a_tag_overflow: assert property (@(posedge clock) disable iff (reset) !(consume && tag_full && !dot_out_rd_en));
  a_orphan_res:   assert property (@(posedge clock) disable iff (reset) !(tag_empty && !dot_out_empty));
endmodule

// File: tb/tb_dot_arbiter.sv
// tb_dot_arbiter: scoreboard bench with behavioural requester FIFOs and a fixed-latency dot model
module tb_dot_arbiter;
  localparam int NUM_REQ = 4;
  localparam int MAX_OUT = 8;
  localparam int LAT = 3;
  typedef logic [2:0][31:0] vec_t;
  typedef struct packed { vec_t x; vec_t y; } op_t;

  logic clock = 1'b0;
  logic reset;
  logic [NUM_REQ-1:0][2:0][31:0] req_x, req_y;
  logic [NUM_REQ-1:0] req_empty, req_rd_en, res_empty, res_rd_en;
  vec_t dot_x, dot_y;
  logic dot_empty, dot_rd_en, dot_out_empty, dot_out_rd_en;
  logic [31:0] dot_out, res_out;
  logic [3:0] outstanding;

  op_t opq[NUM_REQ][$];
  logic [31:0] expq[NUM_REQ][$];
  logic [31:0] dval[$];
  int drdy[$];
  int grant_log[$];
  int cyc, out_model, consumed, errors, checks;

  always #5 clock = ~clock;

  dot_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset(reset), .req_x(req_x), .req_y(req_y), .req_empty(req_empty),
    .req_rd_en(req_rd_en), .dot_x(dot_x), .dot_y(dot_y), .dot_empty(dot_empty),
    .dot_rd_en(dot_rd_en), .dot_out(dot_out), .dot_out_empty(dot_out_empty),
    .dot_out_rd_en(dot_out_rd_en), .res_out(res_out), .res_empty(res_empty),
    .res_rd_en(res_rd_en), .outstanding(outstanding)
  );

  function automatic logic [31:0] dot3(input vec_t x, input vec_t y);
    longint acc = 0;
    for (int k = 0; k < 3; k++) acc += longint'($signed(x[k])) * longint'($signed(y[k]));
    return 32'(acc >>> 16);
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < 3; k++) v[k] = 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
    return v;
  endfunction

  function automatic void refresh();
    for (int r = 0; r < NUM_REQ; r++) begin
      req_empty[r] = (opq[r].size() == 0);
      req_x[r] = '0;
      req_y[r] = '0;
      if (opq[r].size() != 0) begin
        req_x[r] = opq[r][0].x;
        req_y[r] = opq[r][0].y;
      end
    end
    dot_out_empty = 1'b1;
    dot_out = '0;
    if (dval.size() != 0) begin
      dot_out_empty = (drdy[0] > cyc);
      dot_out = dval[0];
    end
  endfunction

  function automatic int pending();
    int n = dval.size();
    for (int r = 0; r < NUM_REQ; r++) n += opq[r].size() + expq[r].size();
    return n;
  endfunction

  function automatic void add_op(input int r, input vec_t x, input vec_t y);
    op_t op;
    op.x = x;
    op.y = y;
    opq[r].push_back(op);
    expq[r].push_back(dot3(x, y));
    refresh();
  endfunction

  // one clock: sample and score just before the edge, advance models just after it
  task automatic tick();
    logic [NUM_REQ-1:0] g;
    logic cons, opop, exp_opop;
    vec_t sx, sy;
    logic [31:0] e;
    #2;
    g = req_rd_en;
    cons = dot_rd_en && !dot_empty;
    sx = dot_x;
    sy = dot_y;
    opop = dot_out_rd_en;
    exp_opop = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (res_rd_en[r] && !res_empty[r]) begin
        exp_opop = 1'b1;
        checks++;
        if (expq[r].size() == 0) begin
          errors++;
          $display("FAIL result_route req=%0d got=%h required=none", r, res_out);
        end else begin
          e = expq[r].pop_front();
          if (res_out !== e) begin
            errors++;
            $display("FAIL result_data req=%0d got=%h required=%h", r, res_out, e);
          end
        end
      end
    end
    checks++;
    if (opop !== exp_opop) begin
      errors++;
      $display("FAIL dot_out_rd_en got=%b required=%b", opop, exp_opop);
    end
    @(posedge clock);
    #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (g[r]) begin
        grant_log.push_back(r);
        if (opq[r].size() != 0) void'(opq[r].pop_front());
      end
    end
    if (cons) begin
      dval.push_back(dot3(sx, sy));
      drdy.push_back(cyc + LAT);
      consumed++;
      out_model++;
    end
    if (opop && dval.size() != 0) begin
      void'(dval.pop_front());
      void'(drdy.pop_front());
      out_model--;
    end
    cyc++;
    refresh();
    checks++;
    if (outstanding !== 4'(out_model)) begin
      errors++;
      $display("FAIL outstanding got=%0d required=%0d", outstanding, out_model);
    end
  endtask

  task automatic start_reset();
    reset = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) begin
      opq[r].delete();
      expq[r].delete();
    end
    dval.delete();
    drdy.delete();
    grant_log.delete();
    out_model = 0;
    dot_rd_en = 1'b0;
    res_rd_en = '0;
    refresh();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic drain();
    dot_rd_en = 1'b1;
    res_rd_en = '1;
    for (int i = 0; i < 300 && pending() != 0; i++) tick();
    res_rd_en = '0;
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", pending());
    end
  endtask

  task automatic test_reset();
    logic [13:0] ctl;
    start_reset();
    @(posedge clock);
    #1;
    ctl = {dot_empty, dot_out_rd_en, req_rd_en, res_empty, outstanding};
    checks++;
    if (ctl !== 14'b1_0_0000_1111_0000) begin
      errors++;
      $display("FAIL reset_ctl got=%b required=%b", ctl, 14'b1_0_0000_1111_0000);
    end
    release_reset();
    #1;
    ctl = {dot_empty, dot_out_rd_en, req_rd_en, res_empty, outstanding};
    checks++;
    if (ctl !== 14'b1_0_0000_1111_0000) begin
      errors++;
      $display("FAIL post_reset_ctl got=%b required=%b", ctl, 14'b1_0_0000_1111_0000);
    end
    checks++;
    if (dot_x !== '0 || dot_y !== '0) begin
      errors++;
      $display("FAIL reset_dot_xy got=%h/%h required=0", dot_x, dot_y);
    end
  endtask

  task automatic test_single();
    vec_t x, y;
    logic ok;
    x = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    y = {32'h0006_0000, 32'h0005_0000, 32'h0004_0000};
    dot_rd_en = 1'b1;
    res_rd_en = '0;
    add_op(2, x, y);
    #1;
    checks++;
    if (req_rd_en !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant got=%b required=0100", req_rd_en);
    end
    tick();
    #1;
    checks++;
    if (dot_empty !== 1'b0 || dot_x !== x || dot_y !== y) begin
      errors++;
      $display("FAIL single_staged empty=%b x=%h y=%h", dot_empty, dot_x, dot_y);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      #1;
      ok = !res_empty[2];
    end
    checks++;
    if (res_empty !== 4'b1011) begin
      errors++;
      $display("FAIL single_res_empty got=%b required=1011", res_empty);
    end
    checks++;
    if (res_out !== 32'h0020_0000) begin
      errors++;
      $display("FAIL single_res_out got=%h required=00200000", res_out);
    end
    res_rd_en = 4'b0100;
    tick();
    res_rd_en = '0;
    #1;
    checks++;
    if (outstanding !== 4'd0 || res_empty !== 4'b1111) begin
      errors++;
      $display("FAIL single_return out=%0d res_empty=%b required 0/1111", outstanding, res_empty);
    end
  endtask

  task automatic test_round_robin();
    start_reset();
    release_reset();
    for (int i = 0; i < 3; i++)
      for (int r = 0; r < NUM_REQ; r++) add_op(r, rand_vec(), rand_vec());
    drain();
    checks++;
    if (grant_log.size() !== 12) begin
      errors++;
      $display("FAIL rr_grant_count got=%0d required=12", grant_log.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (grant_log[i] !== i % NUM_REQ) begin
          errors++;
          $display("FAIL rr_order[%0d] got=%0d required=%0d", i, grant_log[i], i % NUM_REQ);
        end
      end
    end
  endtask

  task automatic test_outstanding_limit();
    start_reset();
    release_reset();
    for (int i = 0; i < 3; i++)
      for (int r = 0; r < NUM_REQ; r++) add_op(r, rand_vec(), rand_vec());
    dot_rd_en = 1'b1;
    repeat (30) tick();
    #1;
    checks++;
    if (grant_log.size() !== MAX_OUT || outstanding !== 4'(MAX_OUT) || dot_empty !== 1'b1) begin
      errors++;
      $display("FAIL limit_hold grants=%0d out=%0d dot_empty=%b required 8/8/1",
               grant_log.size(), outstanding, dot_empty);
    end
    res_rd_en = 4'b0001;
    tick();
    res_rd_en = '0;
    repeat (10) tick();
    #1;
    checks++;
    if (grant_log.size() !== MAX_OUT + 1 || outstanding !== 4'(MAX_OUT) || dot_empty !== 1'b1) begin
      errors++;
      $display("FAIL limit_one_more grants=%0d out=%0d dot_empty=%b required 9/8/1",
               grant_log.size(), outstanding, dot_empty);
    end
    drain();
  endtask

  task automatic test_head_of_line();
    start_reset();
    release_reset();
    add_op(1, rand_vec(), rand_vec());
    add_op(3, rand_vec(), rand_vec());
    dot_rd_en = 1'b1;
    repeat (10) tick();
    #1;
    checks++;
    if (res_empty !== 4'b1101) begin
      errors++;
      $display("FAIL hol_head got=%b required=1101", res_empty);
    end
    res_rd_en = 4'b1000;
    tick();
    #1;
    checks++;
    if (res_empty !== 4'b1101 || outstanding !== 4'd2) begin
      errors++;
      $display("FAIL hol_blocked res_empty=%b out=%0d required 1101/2", res_empty, outstanding);
    end
    res_rd_en = 4'b0010;
    tick();
    res_rd_en = '0;
    #1;
    checks++;
    if (res_empty !== 4'b0111) begin
      errors++;
      $display("FAIL hol_next got=%b required=0111", res_empty);
    end
    res_rd_en = 4'b1000;
    tick();
    res_rd_en = '0;
    #1;
    checks++;
    if (outstanding !== 4'd0 || pending() != 0) begin
      errors++;
      $display("FAIL hol_done out=%0d pending=%0d required 0/0", outstanding, pending());
    end
  endtask

  task automatic test_back_to_back();
    vec_t x0, y0;
    logic stable;
    int c0;
    start_reset();
    release_reset();
    x0 = rand_vec();
    y0 = rand_vec();
    add_op(0, x0, y0);
    for (int i = 0; i < 5; i++) add_op(0, rand_vec(), rand_vec());
    res_rd_en = '1;
    tick();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      stable &= (dot_x === x0) && (dot_y === y0) && (dot_empty === 1'b0);
    end
    checks++;
    if (!stable || grant_log.size() !== 1) begin
      errors++;
      $display("FAIL backpressure_hold stable=%b grants=%0d required 1/1", stable, grant_log.size());
    end
    c0 = consumed;
    dot_rd_en = 1'b1;
    repeat (6) tick();
    checks++;
    if (consumed - c0 !== 6) begin
      errors++;
      $display("FAIL backpressure_stream consumed=%0d required=6", consumed - c0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic [13:0] ctl;
    start_reset();
    release_reset();
    for (int i = 0; i < 6; i++) add_op(1, rand_vec(), rand_vec());
    dot_rd_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      ok = (outstanding == 4'd5);
    end
    checks++;
    if (!ok || dot_empty !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup out=%0d dot_empty=%b required 5/0", outstanding, dot_empty);
    end
    #2;
    start_reset();
    #1;
    ctl = {dot_empty, dot_out_rd_en, req_rd_en, res_empty, outstanding};
    checks++;
    if (ctl !== 14'b1_0_0000_1111_0000 || dot_x !== '0 || dot_y !== '0) begin
      errors++;
      $display("FAIL mid_reset ctl=%b required=%b dot_x=%h", ctl, 14'b1_0_0000_1111_0000, dot_x);
    end
    release_reset();
    add_op(2, rand_vec(), rand_vec());
    drain();
    checks++;
    if (outstanding !== 4'd0 || grant_log.size() !== 1 || grant_log[0] !== 2) begin
      errors++;
      $display("FAIL mid_after out=%0d grants=%0d required 0/1", outstanding, grant_log.size());
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    out_model = 0;
    consumed = 0;
    reset = 1'b1;
    dot_rd_en = 1'b0;
    res_rd_en = '0;
    refresh();
    test_reset();
    test_single();
    test_round_robin();
    test_outstanding_limit();
    test_head_of_line();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dot_arbiter.md
Name: dot_arbiter

Overview:
- Shares one `dot` unit among NUM_REQ requesters, e.g. shading, intersection and reflection stages.
- Each requester presents a FIFO-style operand port (x/y vectors, empty/rd_en).
- Round-robin arbitration picks which requester's operands are staged into the shared `dot` input port.
- An in-order tag FIFO routes each result from the `dot` output FIFO back to the originating requester's result port.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- MAX_OUT, 8, max operations issued to `dot` but not yet returned; also the tag FIFO depth.
- TAG_W, $clog2(NUM_REQ), requester index width (derived, localparam).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_x  in  [NUM_REQ][3]x32 signed  operand vectors x, Q16.16, first-word-fall-through
- req_y  in  [NUM_REQ][3]x32 signed  operand vectors y
- req_empty  in  NUM_REQ  requester operand FIFO empty
- req_rd_en  out  NUM_REQ  pop requester operand FIFO (one-hot or zero)
- dot_x  out  3x32 signed  staged x to `dot`
- dot_y  out  3x32 signed  staged y to `dot`
- dot_empty  out  1  low when staged operands are valid (feeds `dot` in_empty)
- dot_rd_en  in  1  `dot` consumes staged operands (from `dot` in_rd_en)
- dot_out  in  32 signed  `dot` result FIFO head
- dot_out_empty  in  1  `dot` result FIFO empty
- dot_out_rd_en  out  1  pop `dot` result FIFO
- res_out  out  32 signed  result data shared by all requesters
- res_empty  out  NUM_REQ  per-requester result-available (active-low)
- res_rd_en  in  NUM_REQ  requester pops its result
- outstanding  out  $clog2(MAX_OUT+1)  ops issued to `dot` and not yet returned

Behaviour:
- Reset values:
  - Staging FSM = S_IDLE.
  - rr_ptr = 0.
  - Tag FIFO empty; outstanding = 0.
  - dot_x / dot_y = 0; dot_empty = 1.
  - req_rd_en = 0; dot_out_rd_en = 0; res_empty = all 1.
  - Reset mid-operation discards the staged op and all tags. The surrounding FIFOs share the reset.
- Staging FSM, two states:
  - **S_IDLE**: no staged op; dot_empty = 1.
    - grant_ok = (outstanding + 0 < MAX_OUT) and any requester has req_empty = 0.
    - If grant_ok, pick g = first non-empty requester searching from rr_ptr upward, modulo NUM_REQ.
    - Assert req_rd_en[g] combinationally in the same cycle.
    - Register dot_x = req_x[g], dot_y = req_y[g], stag = g.
    - Set rr_ptr = (g+1) mod NUM_REQ; go to S_STAGED.
  - **S_STAGED**: dot_empty = 0; dot_x / dot_y held stable.
    - When dot_rd_en = 1: push stag into the tag FIFO and increment outstanding.
    - In that same cycle, if a further grant is possible (outstanding+1 < MAX_OUT, any requester non-empty), grant and reload, staying in S_STAGED. Otherwise go to S_IDLE.
- Latency: requester non-empty at cycle t while S_IDLE → req_rd_en at t → dot_empty low at t+1.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- Return path:
  - head_tag = tag FIFO head.
  - res_empty[i] = !(i == head_tag and tag FIFO non-empty and dot_out_empty = 0); all other bits = 1.
  - res_out = dot_out, combinational pass-through.
  - When res_rd_en[head_tag] = 1 and res_empty[head_tag] = 0: dot_out_rd_en = 1 (combinational), pop the tag FIFO, decrement outstanding.
  - res_rd_en to any non-head index is ignored. Results return strictly in issue order, so head-of-line blocking is accepted.
- Simultaneous push and pop in one cycle: outstanding is unchanged; the tag FIFO handles a concurrent push/pop when full.
- Tag FIFO cannot overflow: the grant_ok check bounds outstanding ≤ MAX_OUT.
- Dot result present while the tag FIFO is empty is a protocol violation. dot_out_rd_en stays 0; simulation assertion fires.
- Assertions:
  - req_rd_en one-hot or zero.
  - Never pop an empty requester.
  - outstanding ≤ MAX_OUT.

Decomposition:
- Package dot_arb_pkg: state enum {S_IDLE, S_STAGED}, VEC_W = 32, Q_BITS = 16.
- One sub-module, dot_tag_fifo: synchronous FIFO, width TAG_W, depth MAX_OUT.
  - Ports: push, din, pop, dout, empty, full, count.
  - Same-cycle push+pop is legal.

Test Plan:
- **Single request, pass-through:** requester 2 sends x=(1.0,2.0,3.0), y=(4.0,5.0,6.0) in Q16 (0x00010000 = 1.0), real `dot` attached → res_empty[2] falls; res_out = 0x00200000 (32.0). Other res_empty bits stay 1; outstanding returns to 0.
- **Round-robin:** all 4 requesters hold 3 ops each, rr_ptr = 0 → grant order 0,1,2,3,0,1,2,3,0,1,2,3. Each requester receives its own 3 results in order.
- **Outstanding limit:** MAX_OUT = 8, result consumers hold res_rd_en = 0 → exactly 8 grants, outstanding = 8, dot_empty stays 1 afterwards. One pop → exactly one new grant.
- **Head-of-line:** head tag = 1 while requester 3 asserts res_rd_en → no pop. Requester 1 pops → res_empty[3] falls next if tag 3 is next.
- **Back-pressure:** dot_rd_en held 0 for 10 cycles → dot_x / dot_y stable, no further req_rd_en. Release → stream resumes at 1 op/cycle with zero bubbles.
- **Reset mid-flight:** reset with 5 outstanding and a staged op → all outputs at reset values immediately. Post-reset single op returns correctly to its requester.
